// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared constants and encodings for the alarm clock time-of-day chain
package alarm_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SETTLE  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    GRP_NONE    = 2'd0,
    GRP_ALL     = 2'd1,
    GRP_HOURS   = 2'd2,
    GRP_MINUTES = 2'd3
  } grp_t;

  localparam int DIG_SO = 0;
  localparam int DIG_ST = 1;
  localparam int DIG_MO = 2;
  localparam int DIG_MT = 3;
  localparam int DIG_HO = 4;
  localparam int DIG_HT = 5;

  localparam logic [3:0] MAX_SO = 4'd9;
  localparam logic [2:0] MAX_ST = 3'd5;
  localparam logic [3:0] MAX_MO = 4'd9;
  localparam logic [2:0] MAX_MT = 3'd5;
  localparam logic [3:0] MAX_HO = 4'd9;

  localparam logic [1:0] HWRAP_T    = 2'd2;
  localparam logic [3:0] HWRAP_O    = 4'd3;
  localparam logic [1:0] HT_ILLEGAL = 2'd3;

  localparam logic [5:0] BLINK_HR  = 6'b110000;
  localparam logic [5:0] BLINK_MIN = 6'b001100;

endpackage

// File: rtl/tod_carry_decode.sv
// rtl/tod_carry_decode.sv - combinational carry decode for one advance of a digit group
module tod_carry_decode
  import alarm_pkg::*;
(
  input  grp_t       grp,
  input  logic [3:0] s_o,
  input  logic [2:0] s_t,
  input  logic [3:0] m_o,
  input  logic [2:0] m_t,
  input  logic [3:0] h_o,
  input  logic [1:0] h_t,
  output logic [5:0] inc,
  output logic [5:0] ld
);

  logic carry;

  always_comb begin
    inc   = '0;
    ld    = '0;
    carry = (grp == GRP_ALL);
    if (carry) begin
      if (s_o >= MAX_SO) ld[DIG_SO] = 1'b1;
      else begin inc[DIG_SO] = 1'b1; carry = 1'b0; end
    end
    if (carry) begin
      if (s_t >= MAX_ST) ld[DIG_ST] = 1'b1;
      else begin inc[DIG_ST] = 1'b1; carry = 1'b0; end
    end
    if (grp == GRP_MINUTES) carry = 1'b1;
    if (carry) begin
      if (m_o >= MAX_MO) ld[DIG_MO] = 1'b1;
      else begin inc[DIG_MO] = 1'b1; carry = 1'b0; end
    end
    if (carry) begin
      if (m_t >= MAX_MT) ld[DIG_MT] = 1'b1;
      else begin inc[DIG_MT] = 1'b1; carry = 1'b0; end
    end
    // Minute-only advance never reaches the hours; hour-only advance starts there.
    if (grp == GRP_HOURS) carry = 1'b1;
    else if (grp == GRP_MINUTES) carry = 1'b0;
    if (carry) begin
      if (h_t == HT_ILLEGAL || (h_t == HWRAP_T && h_o >= HWRAP_O)) begin
        ld[DIG_HO] = 1'b1;
        ld[DIG_HT] = 1'b1;
      end else if (h_o >= MAX_HO) begin
        ld[DIG_HO]  = 1'b1;
        inc[DIG_HT] = 1'b1;
      end else begin
        inc[DIG_HO] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tod_sequencer.sv
// rtl/tod_sequencer.sv - HH:MM:SS strobe sequencer with set-mode FSM and blink mask
module tod_sequencer
  import alarm_pkg::*;
(
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Tick,
  input  logic       Btn_Mode,
  input  logic       Btn_Inc,
  input  logic [3:0] S_O,
  input  logic [2:0] S_T,
  input  logic [3:0] M_O,
  input  logic [2:0] M_T,
  input  logic [3:0] H_O,
  input  logic [1:0] H_T,
  output logic [5:0] Inc,
  output logic [5:0] Ld,
  output logic [1:0] Mode,
  output logic [5:0] Blink
);

  mode_t      state, state_n, ret, dest;
  grp_t       grp;
  logic       phase, phase_n, pend_tick, pend_tick_n, pend_inc, pend_inc_n;
  logic       tick_e, inc_e, exit_ld;
  logic [5:0] dec_inc, dec_ld, inc_n, ld_n, blink_n;

  tod_carry_decode u_decode (
    .grp (grp),
    .s_o (S_O),
    .s_t (S_T),
    .m_o (M_O),
    .m_t (M_T),
    .h_o (H_O),
    .h_t (H_T),
    .inc (dec_inc),
    .ld  (dec_ld)
  );

  // dest is the user state to be in once any strobe has settled.
  always_comb begin
    tick_e      = 1'b0;
    inc_e       = 1'b0;
    grp         = GRP_NONE;
    dest        = ret;
    exit_ld     = 1'b0;
    pend_tick_n = pend_tick;
    pend_inc_n  = pend_inc;
    if (state == SETTLE) begin
      pend_tick_n = pend_tick | Tick;
      pend_inc_n  = pend_inc | Btn_Inc;
    end else begin
      tick_e      = Tick | pend_tick;
      inc_e       = (Btn_Inc | pend_inc) & ~Btn_Mode;
      pend_tick_n = 1'b0;
      pend_inc_n  = 1'b0;
      dest        = state;
      case (state)
        RUN: begin
          if (tick_e) grp = GRP_ALL;
          if (Btn_Mode) dest = SET_HR;
        end
        SET_HR: begin
          if (inc_e) grp = GRP_HOURS;
          if (Btn_Mode) dest = SET_MIN;
        end
        SET_MIN: begin
          if (Btn_Mode) begin
            dest    = RUN;
            exit_ld = 1'b1;
          end else if (inc_e) begin
            grp = GRP_MINUTES;
          end
        end
        default: ;
      endcase
    end
    phase_n = phase ^ tick_e;
  end

  always_comb begin
    inc_n = dec_inc;
    ld_n  = dec_ld;
    if (exit_ld) ld_n[DIG_ST:DIG_SO] = 2'b11;
    state_n = dest;
    if (|(inc_n | ld_n)) state_n = SETTLE;
    blink_n = '0;
    if (phase_n) begin
      case (dest)
        SET_HR:  blink_n = BLINK_HR;
        SET_MIN: blink_n = BLINK_MIN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state     <= RUN;
      ret       <= RUN;
      phase     <= 1'b0;
      pend_tick <= 1'b0;
      pend_inc  <= 1'b0;
      Inc       <= '0;
      Ld        <= '0;
      Blink     <= '0;
    end else begin
      state     <= state_n;
      ret       <= dest;
      phase     <= phase_n;
      pend_tick <= pend_tick_n;
      pend_inc  <= pend_inc_n;
      Inc       <= inc_n;
      Ld        <= ld_n;
      Blink     <= blink_n;
    end
  end

  assign Mode = state;

endmodule

// File: tb/tb_tod_sequencer.sv
// tb/tb_tod_sequencer.sv - self-checking bench for tod_sequencer with bench-side digit counters
module tb_tod_sequencer;

  logic       Clk = 1'b0;
  logic       Clr = 1'b0;
  logic       Tick = 1'b0, Btn_Mode = 1'b0, Btn_Inc = 1'b0;
  logic [3:0] S_O, M_O, H_O;
  logic [2:0] S_T, M_T;
  logic [1:0] H_T;
  logic [5:0] Inc, Ld, Blink;
  logic [1:0] Mode;

  int dig[6];
  int n_cmp = 0;
  int n_fail = 0;

  assign S_O = 4'(dig[0]);
  assign S_T = 3'(dig[1]);
  assign M_O = 4'(dig[2]);
  assign M_T = 3'(dig[3]);
  assign H_O = 4'(dig[4]);
  assign H_T = 2'(dig[5]);

  tod_sequencer dut (
    .Clk(Clk), .Clr(Clr), .Tick(Tick), .Btn_Mode(Btn_Mode), .Btn_Inc(Btn_Inc),
    .S_O(S_O), .S_T(S_T), .M_O(M_O), .M_T(M_T), .H_O(H_O), .H_T(H_T),
    .Inc(Inc), .Ld(Ld), .Mode(Mode), .Blink(Blink)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [5:0] inc;
    logic [5:0] ld;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    dig[0] = s % 10; dig[1] = s / 10;
    dig[2] = m % 10; dig[3] = m / 10;
    dig[4] = h % 10; dig[5] = h / 10;
  endtask

  function automatic int counter_secs();
    return (dig[5] * 10 + dig[4]) * 3600 + (dig[3] * 10 + dig[2]) * 60 + dig[1] * 10 + dig[0];
  endfunction

  // One clock: drive event, let the counters consume the strobes visible before the edge.
  task automatic step(input logic t, input logic m, input logic i);
    logic [5:0] si, sl;
    Tick = t; Btn_Mode = m; Btn_Inc = i;
    si = Inc;
    sl = Ld;
    @(posedge Clk);
    #1;
    Tick = 1'b0; Btn_Mode = 1'b0; Btn_Inc = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (sl[k]) dig[k] = 0;
      else if (si[k]) dig[k] = dig[k] + 1;
    end
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Clr = 1'b0;
    repeat (2) @(negedge Clk);
    Clr = 1'b1;
    @(negedge Clk);
  endtask

  // Strobes implied by moving the display from one time to another.
  function automatic logic [11:0] strobes(input int oh, input int om, input int os,
                                          input int nh, input int nm, input int ns);
    int od[6];
    int nd[6];
    logic [5:0] si, sl;
    od[0] = os % 10; od[1] = os / 10; od[2] = om % 10; od[3] = om / 10; od[4] = oh % 10; od[5] = oh / 10;
    nd[0] = ns % 10; nd[1] = ns / 10; nd[2] = nm % 10; nd[3] = nm / 10; nd[4] = nh % 10; nd[5] = nh / 10;
    si = '0;
    sl = '0;
    for (int k = 0; k < 6; k++) begin
      if (nd[k] != od[k]) begin
        if (nd[k] == 0) sl[k] = 1'b1;
        else si[k] = 1'b1;
      end
    end
    return {si, sl};
  endfunction

  initial begin
    int mh, mm, ms, mst, secs;
    logic mph;
    logic t, m, i;
    logic [11:0] st;
    logic [5:0] ei, el, eb;

    tbl[0] = '{5'd0,  6'd0,  6'd0,  6'b000001, 6'b000000};
    tbl[1] = '{5'd0,  6'd0,  6'd9,  6'b000010, 6'b000001};
    tbl[2] = '{5'd0,  6'd0,  6'd59, 6'b000100, 6'b000011};
    tbl[3] = '{5'd0,  6'd9,  6'd59, 6'b001000, 6'b000111};
    tbl[4] = '{5'd0,  6'd59, 6'd59, 6'b010000, 6'b001111};
    tbl[5] = '{5'd12, 6'd59, 6'd59, 6'b010000, 6'b001111};
    tbl[6] = '{5'd9,  6'd59, 6'd59, 6'b100000, 6'b011111};
    tbl[7] = '{5'd19, 6'd59, 6'd59, 6'b100000, 6'b011111};
    tbl[8] = '{5'd23, 6'd59, 6'd59, 6'b000000, 6'b111111};

    set_time(0, 0, 0);
    repeat (3) @(negedge Clk);
    Clr = 1'b1;
    @(negedge Clk);
    chk("reset_state", {Inc, Ld, Mode, Blink}, 20'h0);

    // Clear asserted while a strobe is on the outputs.
    Tick = 1'b1;
    @(posedge Clk);
    #1;
    Tick = 1'b0;
    chk("pre_clr_inc", Inc, 6'b000001);
    Clr = 1'b0;
    #1;
    chk("clr_async", {Inc, Ld, Mode, Blink}, 20'h0);
    @(negedge Clk);
    Clr = 1'b1;
    @(negedge Clk);

    for (int k = 0; k < 9; k++) begin
      set_time(int'(tbl[k].h), int'(tbl[k].m), int'(tbl[k].s));
      step(1'b1, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_inc", k), Inc, tbl[k].inc);
      chk($sformatf("tbl%0d_ld", k), Ld, tbl[k].ld);
      chk($sformatf("tbl%0d_mode", k), Mode, 2'd3);
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_after", k), {Inc, Ld, Mode, Blink}, 20'h0);
    end

    do_reset();
    set_time(23, 45, 0);
    step(1'b0, 1'b1, 1'b0);
    chk("enter_set_hr", {Inc, Ld, Mode, Blink}, {6'b0, 6'b0, 2'd1, 6'b0});
    step(1'b0, 1'b0, 1'b1);
    chk("set_hr_wrap", {Inc, Ld, Mode}, {6'b0, 6'b110000, 2'd3});
    step(1'b0, 1'b0, 1'b0);
    chk("set_hr_settled", Mode, 2'd1);
    chk("set_hr_time", counter_secs(), 45 * 60);
    step(1'b1, 1'b0, 1'b0);
    chk("set_hr_tick", {Inc, Ld, Mode, Blink}, {6'b0, 6'b0, 2'd1, 6'b110000});
    step(1'b1, 1'b0, 1'b0);
    chk("set_hr_tick2", Blink, 6'b0);
    dig[5] = 3; dig[4] = 1;
    step(1'b0, 1'b0, 1'b1);
    chk("set_hr_illegal", {Inc, Ld}, {6'b0, 6'b110000});
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("enter_set_min", {Inc, Ld, Mode, Blink}, {6'b0, 6'b0, 2'd2, 6'b0});
    set_time(0, 59, 37);
    step(1'b0, 1'b0, 1'b1);
    chk("set_min_wrap", {Inc, Ld, Mode}, {6'b0, 6'b001100, 2'd3});
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("exit_set_min", {Inc, Ld, Mode}, {6'b0, 6'b000011, 2'd3});
    step(1'b0, 1'b0, 1'b0);
    chk("exit_settled", Mode, 2'd0);
    chk("exit_time", counter_secs(), 0);

    step(1'b0, 1'b1, 1'b1);
    chk("mode_inc_run", {Inc, Ld, Mode}, {6'b0, 6'b0, 2'd1});
    step(1'b0, 1'b1, 1'b1);
    chk("mode_inc_hr", {Inc, Ld, Mode}, {6'b0, 6'b0, 2'd2});
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("back_to_run", Mode, 2'd0);

    set_time(0, 0, 5);
    step(1'b1, 1'b0, 1'b0);
    chk("tick_a", {Inc, Mode}, {6'b000001, 2'd3});
    step(1'b1, 1'b0, 1'b0);
    chk("tick_in_settle", {Inc, Ld, Mode}, {6'b0, 6'b0, 2'd0});
    step(1'b0, 1'b0, 1'b0);
    chk("pending_tick", {Inc, Ld, Mode}, {6'b000001, 6'b0, 2'd3});
    step(1'b0, 1'b0, 1'b0);
    chk("pending_done", {Inc, Ld, Mode}, {6'b0, 6'b0, 2'd0});
    chk("pending_time", counter_secs(), 7);
    step(1'b1, 1'b1, 1'b0);
    chk("tick_mode_run", {Inc, Mode}, {6'b000001, 2'd3});
    step(1'b0, 1'b0, 1'b0);
    chk("tick_mode_after", {Mode, counter_secs()}, {2'd1, 32'd8});

    // Randomized events, one per two cycles, against an arithmetic time model.
    do_reset();
    set_time(23, 58, 50);
    mh = 23; mm = 58; ms = 50; mst = 0; mph = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      t = 1'($urandom_range(0, 1));
      m = ($urandom_range(0, 6) == 0);
      i = ($urandom_range(0, 2) != 0);
      ei = '0;
      el = '0;
      if (t) mph = ~mph;
      case (mst)
        0: begin
          if (t) begin
            secs = (mh * 3600 + mm * 60 + ms + 1) % 86400;
            st = strobes(mh, mm, ms, secs / 3600, (secs / 60) % 60, secs % 60);
            {ei, el} = st;
            mh = secs / 3600; mm = (secs / 60) % 60; ms = secs % 60;
          end
          if (m) mst = 1;
        end
        1: begin
          if (m) mst = 2;
          else if (i) begin
            st = strobes(mh, mm, ms, (mh + 1) % 24, mm, ms);
            {ei, el} = st;
            mh = (mh + 1) % 24;
          end
        end
        default: begin
          if (m) begin
            mst = 0; ms = 0; el = 6'b000011;
          end else if (i) begin
            st = strobes(mh, mm, ms, mh, (mm + 1) % 60, ms);
            {ei, el} = st;
            mm = (mm + 1) % 60;
          end
        end
      endcase
      eb = '0;
      if (mph && mst == 1) eb = 6'b110000;
      if (mph && mst == 2) eb = 6'b001100;
      step(t, m, i);
      chk("rnd_event", {Inc, Ld, Mode, Blink},
          {ei, el, ((ei | el) != 0) ? 2'd3 : 2'(mst), eb});
      step(1'b0, 1'b0, 1'b0);
      chk("rnd_settled", {Inc, Ld, Mode, Blink}, {6'b0, 6'b0, 2'(mst), eb});
      chk("rnd_time", counter_secs(), mh * 3600 + mm * 60 + ms);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
